// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock with a
// registered carry, start/ready accept handshake and a one-cycle done pulse.
module chunked_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic [1:0]       state_dbg
);

    localparam int NCHUNK = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("chunked_addsub: CHUNK must be >= 1 and divide WIDTH");
    end

    // state_dbg encoding is part of the debug interface: IDLE=0, RUN=1, DONE=2.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [KW-1:0]    k_q, k_d;

    logic [CHUNK:0]   slice;
    logic [WIDTH-1:0] slice_ext;
    logic [WIDTH-1:0] acc_shift;

    // Low chunk of the shifting operands feeds the single slice adder; its sum
    // enters the accumulator from the top so the result ends up in place.
    always_comb begin
        slice     = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_q};
        slice_ext = WIDTH'(slice[CHUNK-1:0]);
        acc_shift = (acc_q >> CHUNK) | (slice_ext << (WIDTH - CHUNK));
    end

    // Handshake: an operation is accepted on a rising edge where ready=1 and
    // start=1; operands are sampled only then, and done pulses for one cycle.
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        k_d      = k_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub | cin;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_shift;
                opa_d   = opa_q >> CHUNK;
                opb_d   = opb_q >> CHUNK;
                carry_d = slice[CHUNK];
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    result_d = acc_shift;
                    cout_d   = slice[CHUNK];
                    ovf_d    = (opa_q[CHUNK-1] == opb_q[CHUNK-1])
                            && (slice[CHUNK-1] != opa_q[CHUNK-1]);
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            k_q      <= k_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: three parameterisations (16/4, 16/16, 12/3) checked
// against an arithmetic reference model and directed spec vectors.
module tb_chunked_addsub;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        start, sub, cin;
    logic [15:0] a, b;
    int          sel;

    logic [2:0]  start_v;
    logic [2:0]  rdy_v, done_v, cout_v, ovf_v;
    logic [15:0] res0, res1;
    logic [11:0] res2;
    logic [1:0]  st0, st1, st2;

    assign start_v = {start && (sel == 2), start && (sel == 1), start && (sel == 0)};

    chunked_addsub #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .reset(reset), .start(start_v[0]), .sub(sub), .cin(cin),
        .a(a), .b(b), .ready(rdy_v[0]), .done(done_v[0]), .result(res0),
        .cout(cout_v[0]), .overflow(ovf_v[0]), .state_dbg(st0)
    );

    chunked_addsub #(.WIDTH(16), .CHUNK(16)) u_dut_w (
        .clk(clk), .reset(reset), .start(start_v[1]), .sub(sub), .cin(cin),
        .a(a), .b(b), .ready(rdy_v[1]), .done(done_v[1]), .result(res1),
        .cout(cout_v[1]), .overflow(ovf_v[1]), .state_dbg(st1)
    );

    chunked_addsub #(.WIDTH(12), .CHUNK(3)) u_dut_n (
        .clk(clk), .reset(reset), .start(start_v[2]), .sub(sub), .cin(cin),
        .a(a[11:0]), .b(b[11:0]), .ready(rdy_v[2]), .done(done_v[2]), .result(res2),
        .cout(cout_v[2]), .overflow(ovf_v[2]), .state_dbg(st2)
    );

    logic        cur_ready, cur_done, cur_cout, cur_ovf;
    logic [15:0] cur_result;
    logic [1:0]  cur_state;
    assign cur_ready  = rdy_v[sel];
    assign cur_done   = done_v[sel];
    assign cur_cout   = cout_v[sel];
    assign cur_ovf    = ovf_v[sel];
    assign cur_result = (sel == 2) ? {4'b0, res2} : (sel == 1) ? res1 : res0;
    assign cur_state  = (sel == 2) ? st2 : (sel == 1) ? st1 : st0;

    // ---------------- scoreboard ----------------
    int          n_checks;
    int          n_fail;
    logic [17:0] exp_q[$];      // {overflow, cout, result}
    logic [17:0] last_exp[3];   // last completed result per instance

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int width_of(input int s);
        return (s == 2) ? 12 : 16;
    endfunction

    function automatic int nchunk_of(input int s);
        return (s == 1) ? 1 : 4;
    endfunction

    // Reference: plain integer arithmetic; overflow from the true signed result.
    function automatic logic [17:0] model(input int w, input logic s, input logic ci,
                                          input logic [15:0] av, input logic [15:0] bv);
        longint mask, half, ua, ub, sa, sb, full, sr;
        logic   o, co;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        if (s) begin
            full = ua + (mask - ub) + 1;
            sr   = sa - sb;
        end else begin
            full = ua + ub + longint'(ci);
            sr   = sa + sb + longint'(ci);
        end
        co = ((full >> w) & 1) != 0;
        o  = (sr >= half) || (sr < -half);
        return {o, co, 16'(full & mask)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (cur_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(cur_ready), 32'd1);
    endtask

    task automatic do_op(input int s_sel, input logic s, input logic ci,
                         input logic [15:0] av, input logic [15:0] bv,
                         input logic [17:0] e_in, input string tag);
        int          n;
        int          lat;
        logic [17:0] e;
        sel = s_sel;
        n   = nchunk_of(s_sel);
        wait_ready(tag);
        start = 1'b1; sub = s; cin = ci; a = av; b = bv;
        exp_q.push_back(e_in);
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        sub = 1'($urandom); cin = 1'($urandom);
        check({tag, "_ready_low"}, 32'(cur_ready), 32'd0);
        lat = 1;
        while (cur_done !== 1'b1 && lat < 40) begin
            check({tag, "_run_hold"}, 32'(cur_result), 32'(last_exp[s_sel][15:0]));
            check({tag, "_run_state"}, 32'(cur_state), 32'd1);
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(n + 1));
        check({tag, "_done"}, 32'(cur_done), 32'd1);
        check({tag, "_ready_in_done"}, 32'(cur_ready), 32'd0);
        e = exp_q.pop_front();
        check({tag, "_result"}, 32'(cur_result), 32'(e[15:0]));
        check({tag, "_cout"}, 32'(cur_cout), 32'(e[16]));
        check({tag, "_ovf"}, 32'(cur_ovf), 32'(e[17]));
        last_exp[s_sel] = e;
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(cur_done), 32'd0);
        check({tag, "_ready_back"}, 32'(cur_ready), 32'd1);
        check({tag, "_result_hold"}, 32'(cur_result), 32'(e[15:0]));
    endtask

    task automatic do_rand(input int s_sel, input string tag);
        logic        s, ci;
        logic [15:0] av, bv;
        s  = 1'($urandom);
        ci = 1'($urandom);
        av = 16'($urandom);
        bv = 16'($urandom_range(0, 3) == 0 ? 16'h8000 : $urandom);
        do_op(s_sel, s, ci, av, bv, model(width_of(s_sel), s, ci, av, bv), tag);
    endtask

    task automatic back_to_back(input string tag);
        int          p;
        logic [17:0] e;
        sel = 0;
        p   = nchunk_of(0) + 2;
        wait_ready(tag);
        for (int t = 0; t < 4 * p; t++) begin
            if (t > 0) begin
                check({tag, "_done"}, 32'(cur_done), 32'((t % p) == p - 1));
                check({tag, "_ready"}, 32'(cur_ready), 32'((t % p) == 0));
                if ((t % p) == p - 1) begin
                    e = exp_q.pop_front();
                    check({tag, "_result"}, 32'(cur_result), 32'(e[15:0]));
                    check({tag, "_cout"}, 32'(cur_cout), 32'(e[16]));
                    check({tag, "_ovf"}, 32'(cur_ovf), 32'(e[17]));
                    last_exp[0] = e;
                end else begin
                    check({tag, "_hold"}, 32'(cur_result), 32'(last_exp[0][15:0]));
                end
            end
            start = 1'b1;
            a = 16'($urandom); b = 16'($urandom);
            sub = 1'($urandom); cin = 1'($urandom);
            if ((t % p) == 0) exp_q.push_back(model(16, sub, cin, a, b));
            @(negedge clk);
        end
        check({tag, "_ready_end"}, 32'(cur_ready), 32'd1);
        start = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_ready"}, 32'(rdy_v), 32'h7);
        check({tag, "_done"}, 32'(done_v), 32'h0);
        check({tag, "_cout"}, 32'(cout_v), 32'h0);
        check({tag, "_ovf"}, 32'(ovf_v), 32'h0);
        check({tag, "_res0"}, 32'(res0), 32'h0);
        check({tag, "_res1"}, 32'(res1), 32'h0);
        check({tag, "_res2"}, 32'(res2), 32'h0);
        check({tag, "_state"}, 32'({st2, st1, st0}), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 3; i++) last_exp[i] = '0;
        reset = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0;
        a = '0; b = '0; sel = 0;
        repeat (2) @(negedge clk);
        reset_checks("por");
        reset = 1'b1;
        @(negedge clk);

        do_op(0, 1'b0, 1'b0, 16'h1234, 16'h0FFF, {1'b0, 1'b0, 16'h2233}, "add_basic");
        do_op(0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, {1'b0, 1'b1, 16'h0000}, "add_wrap");
        do_op(0, 1'b0, 1'b1, 16'h7FFF, 16'h0000, {1'b1, 1'b0, 16'h8000}, "add_cin_ovf");
        do_op(0, 1'b1, 1'b0, 16'h0005, 16'h0007, {1'b0, 1'b0, 16'hFFFE}, "sub_borrow");
        do_op(0, 1'b1, 1'b0, 16'h8000, 16'h0001, {1'b1, 1'b1, 16'h7FFF}, "sub_ovf");
        do_op(0, 1'b1, 1'b1, 16'h0005, 16'h0007, {1'b0, 1'b0, 16'hFFFE}, "sub_borrow_cin");
        do_op(0, 1'b1, 1'b1, 16'h8000, 16'h0001, {1'b1, 1'b1, 16'h7FFF}, "sub_ovf_cin");

        back_to_back("b2b");

        // Abort an operation two cycles into RUN.
        sel = 0;
        wait_ready("abort");
        start = 1'b1; sub = 1'b0; cin = 1'b0; a = 16'h1111; b = 16'h2222;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset_checks("abort_now");
        @(negedge clk);
        reset_checks("abort_held");
        reset = 1'b1;
        last_exp[0] = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done_v[0]), 32'd0);
        end
        do_op(0, 1'b0, 1'b0, 16'h0001, 16'h0001, {1'b0, 1'b0, 16'h0002}, "post_reset");

        for (int i = 0; i < 12; i++) do_rand(0, "rand_c4");

        do_op(1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, {1'b0, 1'b1, 16'hFFFE}, "w16_add");
        for (int i = 0; i < 5; i++) do_rand(1, "rand_c16");

        do_op(2, 1'b0, 1'b0, 16'h0FFF, 16'h0001, {1'b0, 1'b1, 16'h0000}, "w12_add");
        do_op(2, 1'b1, 1'b0, 16'h0800, 16'h0001, {1'b1, 1'b1, 16'h07FF}, "w12_sub_ovf");
        for (int i = 0; i < 5; i++) do_rand(2, "rand_c3");

        // ---------------- final report ----------------
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/chunked_addsub.md
Name: chunked_addsub

Overview:
- Parametrised multi-cycle adder/subtractor for the datapath.
- Processes a WIDTH-bit add or subtract CHUNK bits per clock, using one CHUNK-bit adder slice and a registered carry.
- Accepts operands through a start/ready handshake and reports completion with a one-cycle done pulse.
- Result, carry-out and signed overflow are held stable between operations.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle, 1..WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request to begin an operation; accepted only when ready=1.
- sub  input  1  0 = add, 1 = subtract (a - b); sampled on accept.
- cin  input  1  carry-in for add; ignored when sub=1; sampled on accept.
- a  input  WIDTH  operand A; sampled on accept.
- b  input  WIDTH  operand B; sampled on accept.
- ready  output  1  high only in IDLE.
- done  output  1  one-cycle pulse, high only in DONE.
- result  output  WIDTH  registered sum or difference.
- cout  output  1  carry out of bit WIDTH-1. For subtract, 1 means no borrow.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- States: IDLE, RUN, DONE.
  - ready = (state==IDLE), decoded combinationally from the state register.
  - done = (state==DONE).
- Accept occurs at a rising edge where state==IDLE and start=1. On accept:
  - Latch opA=a.
  - Latch opB = sub ? ~b : b (ones-complement on subtract).
  - Set carry = sub ? 1 : cin.
  - Clear chunk counter k=0; state goes to RUN.
- RUN, each edge:
  - Add opA[CHUNK-1:0] + opB[CHUNK-1:0] + carry.
  - Write the CHUNK-bit sum into the top of a shift accumulator, shifting the accumulator right by CHUNK.
  - Shift opA and opB right by CHUNK.
  - carry <= slice carry-out; k <= k+1.
- On the edge where k==NCHUNK-1:
  - Load result <= final accumulator value, including the last chunk.
  - Load cout <= slice carry-out.
  - Load overflow <= (opA msb == opB msb) && (sum msb != opA msb), using the top bits of the final slice.
  - State goes to DONE.
- DONE lasts exactly one cycle, then IDLE unconditionally. start is ignored while in DONE.
- Latency: when accepted at edge E, done is high in the cycle following edge E+NCHUNK, and ready returns after edge E+NCHUNK+1. Back-to-back throughput is one operation per NCHUNK+2 cycles.
- start in RUN or DONE is ignored; operand changes after accept have no effect.
- result, cout and overflow change only at the completion edge. They hold their values through IDLE and through the next operation's RUN.
- CHUNK==WIDTH: RUN lasts one cycle, so done appears one cycle after accept.
- Arithmetic is modulo 2^WIDTH.
  - Subtract computes a + ~b + 1.
  - Add computes a + b + cin.
- Reset (reset=0, asynchronous, at any time including mid-RUN):
  - State goes to IDLE.
  - result=0, cout=0, overflow=0, done=0.
  - Internal operands, carry and k are cleared.
  - ready=1 while reset is held and after release.
  - An aborted operation produces no done.
- Elaboration must fail if WIDTH % CHUNK != 0 or CHUNK < 1.

Test Plan:
- Defaults, add 0x1234+0x0FFF, cin=0 -> result 0x2233, cout 0, ovf 0; done 4 cycles after the accept edge, single pulse; ready low for 5 cycles.
- Add 0xFFFF+0x0001, cin=0 -> 0x0000, cout 1, ovf 0. Add 0x7FFF+0x0000, cin=1 -> 0x8000, cout 0, ovf 1.
- Sub 0x0005-0x0007 -> 0xFFFE, cout 0, ovf 0. Sub 0x8000-0x0001 -> 0x7FFF, cout 1, ovf 1. Drive cin=1 during the subtract -> same results.
- Hold start=1 continuously with changing a/b -> accepts occur only in IDLE, every 6 cycles. Each result matches the operands present at its accept edge. result stays unchanged during RUN.
- Assert reset=0 two cycles into RUN -> immediately ready=1, done=0, result=0. After release, 0x0001+0x0001 -> 0x0002 with normal latency.
- WIDTH=16, CHUNK=16 -> 0xFFFF+0xFFFF -> 0xFFFE, cout 1, done one cycle after accept. WIDTH=12, CHUNK=3 -> 0xFFF+0x001 -> 0x000, cout 1, 4-cycle latency.
